// File: rtl/alu_pkg.sv
// Shared constants and sequencer state encoding for the 64-bit-over-32-bit ALU sequencer.
package alu_pkg;

    localparam int unsigned ALU_W  = 32;
    localparam int unsigned WIDE_W = 64;
    localparam int unsigned CTRL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu64_seq_if.sv
// Request, response and ALU-lane signals of alu64_seq; slave is the sequencer's view,
// master is the upstream requester / downstream consumer / ALU side.
interface alu64_seq_if;
    import alu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [WIDE_W-1:0]   req_a;
    logic [WIDE_W-1:0]   req_b;
    logic                req_c;
    logic [CTRL_W-1:0]   req_ctrl;

    logic [ALU_W-1:0]    alu_in_a;
    logic [ALU_W-1:0]    alu_in_b;
    logic                alu_in_c;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic [ALU_W-1:0]    alu_out;
    logic                alu_c_out;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDE_W-1:0]   rsp_result;
    logic                rsp_c_out;
    logic                rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_ctrl,
        output req_ready,
        output alu_in_a, alu_in_b, alu_in_c, alu_ctrl,
        input  alu_out, alu_c_out,
        output rsp_valid, rsp_result, rsp_c_out, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_c, req_ctrl,
        input  req_ready,
        input  alu_in_a, alu_in_b, alu_in_c, alu_ctrl,
        output alu_out, alu_c_out,
        input  rsp_valid, rsp_result, rsp_c_out, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu64_seq.sv
// Runs one 64-bit operation as a low then high pass through an external 32-bit ALU.
// ALU64_SEQ_CARRY_CHAIN_EN: when defined, the high pass takes the low pass carry-out.
module alu64_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu64_seq_if.slave  bus
);

    seq_state_t          state_q, state_d;
    logic [WIDE_W-1:0]   a_q, a_d;
    logic [WIDE_W-1:0]   b_q, b_d;
    logic                c_q, c_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDE_W-1:0]   result_q, result_d;
    logic                c_out_q, c_out_d;
    logic                zero_q, zero_d;
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
    logic                lo_c_q, lo_c_d;
`endif

    logic                hi_c_in;

`ifdef ALU64_SEQ_CARRY_CHAIN_EN
    assign hi_c_in = lo_c_q;
`else
    assign hi_c_in = c_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        zero_d   = zero_q;
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
        lo_c_d   = lo_c_q;
`endif
        bus.alu_in_a = '0;
        bus.alu_in_b = '0;
        bus.alu_in_c = 1'b0;
        bus.alu_ctrl = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    c_d     = bus.req_c;
                    ctrl_d  = bus.req_ctrl;
                    state_d = LO;
                end
            end
            LO: begin
                bus.alu_in_a           = a_q[ALU_W-1:0];
                bus.alu_in_b           = b_q[ALU_W-1:0];
                bus.alu_in_c           = c_q;
                bus.alu_ctrl           = ctrl_q;
                result_d[ALU_W-1:0]    = bus.alu_out;
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
                lo_c_d                 = bus.alu_c_out;
`endif
                state_d                = HI;
            end
            HI: begin
                bus.alu_in_a           = a_q[WIDE_W-1:ALU_W];
                bus.alu_in_b           = b_q[WIDE_W-1:ALU_W];
                bus.alu_in_c           = hi_c_in;
                bus.alu_ctrl           = ctrl_q;
                result_d[WIDE_W-1:ALU_W] = bus.alu_out;
                c_out_d                = bus.alu_c_out;
                // Low half is already registered, so the zero flag is ready with the high half.
                zero_d                 = (bus.alu_out == '0) && (result_q[ALU_W-1:0] == '0);
                state_d                = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= 1'b0;
            ctrl_q   <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
            lo_c_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            zero_q   <= zero_d;
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
            lo_c_q   <= lo_c_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_c_out  = c_out_q;
    assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu64_seq.sv
// Directed self-checking bench for alu64_seq with an adder standing in for alu32bit.
module tb_alu64_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu64_seq_if bus ();

    alu64_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU model: in_a + in_b + in_c for every ctrl value.
    logic [32:0] sum;
    always_comb begin
        sum = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b} + {32'd0, bus.alu_in_c};
    end
    assign bus.alu_out   = sum[31:0];
    assign bus.alu_c_out = sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drops req_valid after the accept edge and counts negedges until rsp_valid (0 = timeout).
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input logic [1:0] ctrl);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_c     = c;
        bus.req_ctrl  = ctrl;
        bus.req_valid = 1'b1;
    endtask

    task automatic test_reset;
        int seen;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 64'd0 ||
            bus.alu_in_a !== 32'd0 || bus.alu_ctrl !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h alu_a=%h ctrl=%0d, want 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.alu_in_a, bus.alu_ctrl);
        end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        send(64'h0000_0003_0000_0005, 64'h0000_0004_0000_0007, 1'b0, 2'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_in_a !== 32'h0000_0003) begin
            errors++;
            $display("FAIL reset_hi_operand: got %h want %h", bus.alu_in_a, 32'h3);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_op: ready=%b valid=%b result=%h, want 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_rsp: rsp_valid seen %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_carry;
        int n;
        bus.rsp_ready = 1'b0;
        send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 2'd0);
        wait_rsp(n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL carry_latency: got %0d edges want 3", n);
        end
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
        checks++;
        if (bus.rsp_result !== 64'h0000_0001_0000_0000 || bus.rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL carry_result: got %h zero=%b want %h zero=0",
                     bus.rsp_result, bus.rsp_zero, 64'h0000_0001_0000_0000);
        end
`else
        checks++;
        if (bus.rsp_result !== 64'h0 || bus.rsp_zero !== 1'b1) begin
            errors++;
            $display("FAIL carry_result: got %h zero=%b want 0 zero=1",
                     bus.rsp_result, bus.rsp_zero);
        end
`endif
        checks++;
        if (bus.rsp_c_out !== 1'b0) begin
            errors++;
            $display("FAIL carry_cout: got %b want 0", bus.rsp_c_out);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL carry_release: valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_all_ones;
        int n;
        bus.rsp_ready = 1'b0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd0);
        wait_rsp(n);
        checks++;
        if (n != 3 || bus.rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.rsp_c_out !== 1'b1 ||
            bus.rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL all_ones: lat=%0d result=%h cout=%b zero=%b want 3 ffffffffffffffff 1 0",
                     n, bus.rsp_result, bus.rsp_c_out, bus.rsp_zero);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall;
        int n;
        bus.rsp_ready = 1'b0;
        send(64'h1, 64'h2, 1'b0, 2'd0);
        wait_rsp(n);
        checks++;
        if (n != 3 || bus.rsp_result !== 64'h3) begin
            errors++;
            $display("FAIL stall_first: lat=%0d result=%h want 3 3", n, bus.rsp_result);
        end
        send(64'd10, 64'd20, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'h3 ||
                bus.rsp_c_out !== 1'b0 || bus.rsp_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: ready=%b valid=%b result=%h cout=%b zero=%b want 0 1 3 0 0",
                         i, bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_c_out,
                         bus.rsp_zero);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
        end
        bus.rsp_ready = 1'b0;
        wait_rsp(n);
        checks++;
        if (n != 3 || bus.rsp_result !== 64'd30) begin
            errors++;
            $display("FAIL stall_second: lat=%0d result=%h want 3 1e", n, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ctrl;
        int n;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.alu_ctrl !== 2'd0) begin
            errors++;
            $display("FAIL ctrl_idle: got %0d want 0", bus.alu_ctrl);
        end
        send(64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 2'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.alu_ctrl !== 2'd2 || bus.alu_in_a !== 32'h9ABC_DEF0 || bus.alu_in_c !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_lo: ctrl=%0d a=%h c=%b want 2 9abcdef0 1",
                     bus.alu_ctrl, bus.alu_in_a, bus.alu_in_c);
        end
        @(negedge clk);
        checks++;
        if (bus.alu_ctrl !== 2'd2 || bus.alu_in_a !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ctrl_hi: ctrl=%0d a=%h want 2 12345678", bus.alu_ctrl, bus.alu_in_a);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.alu_ctrl !== 2'd0 || bus.alu_in_a !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_done: valid=%b ctrl=%0d a=%h want 1 0 0",
                     bus.rsp_valid, bus.alu_ctrl, bus.alu_in_a);
        end
`ifdef ALU64_SEQ_CARRY_CHAIN_EN
        checks++;
        if (bus.rsp_result !== 64'h1234_5678_9ABC_DEF1) begin
            errors++;
            $display("FAIL ctrl_result: got %h want 123456789abcdef1", bus.rsp_result);
        end
`else
        checks++;
        if (bus.rsp_result !== 64'h1234_5679_9ABC_DEF1) begin
            errors++;
            $display("FAIL ctrl_result: got %h want 123456799abcdef1", bus.rsp_result);
        end
`endif
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.alu_ctrl !== 2'd0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ctrl_after: ctrl=%0d ready=%b want 0 1", bus.alu_ctrl, bus.req_ready);
        end
        n = 0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = 1'b0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b0;
        test_reset;
        test_carry;
        test_all_ones;
        test_stall;
        test_ctrl;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
